// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned MEM_LAT_MIN = 1;
    localparam int unsigned MEM_LAT_MAX = 15;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        INST = 2'b10
    } state_e;

    typedef enum logic {
        OWN_DATA = 1'b0,
        OWN_INST = 1'b1
    } owner_e;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    // Counter preload for a given latency, clamped into the legal range.
    function automatic logic [CNT_W-1:0] lat_load(input int unsigned lat);
        int unsigned l;
        l = lat;
        if (l < MEM_LAT_MIN) l = MEM_LAT_MIN;
        if (l > MEM_LAT_MAX) l = MEM_LAT_MAX;
        return CNT_W'(l - 1);
    endfunction

endpackage

// File: rtl/mem_arb_cnt.sv
// Access-latency down-counter: loads at grant, counts down while busy, flags zero.
module mem_arb_cnt
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturate at zero; the FSM leaves the busy state on that edge anyway.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one single-ported memory.
// Optional round-robin tie-break when MEM_ARB_RR_EN is defined (default: data wins).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              dm_stall,
    input  logic              halt,
    output logic              m_en,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    state_e   state_q;
    state_e   state_d;
    mem_cmd_t cmd_q;
    mem_cmd_t cmd_d;
    logic     grant_dm;
    logic     grant_if;
    logic     cnt_zero;

`ifdef MEM_ARB_RR_EN
    owner_e   last_q;
    owner_e   last_d;
`endif

    // Grant decision; only taken in IDLE, halt masks fetches.
    always_comb begin
        grant_dm = 1'b0;
        grant_if = 1'b0;
        if (state_q == IDLE) begin
`ifdef MEM_ARB_RR_EN
            if (dm_req && if_req && !halt) begin
                grant_dm = (last_q == OWN_INST);
                grant_if = (last_q == OWN_DATA);
            end else begin
                grant_dm = dm_req;
                grant_if = if_req && !halt && !dm_req;
            end
`else
            grant_dm = dm_req;
            grant_if = if_req && !halt && !dm_req;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    state_d = DATA;
                end else if (grant_if) begin
                    state_d = INST;
                end
            end
            DATA, INST: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Winner's command is captured at grant and held for the whole access.
    always_comb begin
        cmd_d = cmd_q;
        if (grant_dm) begin
            cmd_d = '{wr: dm_wr, addr: dm_addr, wdata: dm_wdata};
        end else if (grant_if) begin
            cmd_d = '{wr: 1'b0, addr: if_addr, wdata: '0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q <= '0;
        end else begin
            cmd_q <= cmd_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_comb begin
        last_d = last_q;
        if (grant_dm) begin
            last_d = OWN_DATA;
        end else if (grant_if) begin
            last_d = OWN_INST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= OWN_INST;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    mem_arb_cnt u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (grant_dm || grant_if),
        .load_val_i (lat_load(MEM_LAT)),
        .dec_i      (state_q != IDLE),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        m_en     = 1'b0;
        m_wr     = 1'b0;
        m_addr   = cmd_q.addr;
        m_wdata  = cmd_q.wdata;
        if_done  = 1'b0;
        dm_done  = 1'b0;
        if_rdata = '0;
        dm_rdata = '0;
        case (state_q)
            DATA: begin
                m_en    = 1'b1;
                m_wr    = cmd_q.wr;
                dm_done = cnt_zero;
                if (cnt_zero) begin
                    dm_rdata = m_rdata;
                end
            end
            INST: begin
                m_en    = 1'b1;
                m_wr    = cmd_q.wr;
                if_done = cnt_zero;
                if (cnt_zero) begin
                    if_rdata = m_rdata;
                end
            end
            default: ;
        endcase
        if_stall = if_req && !if_done;
        dm_stall = dm_req && !dm_done;
    end

endmodule
